// File: rtl/regfile_2r1w.sv
// 32x32 general-purpose register file with two combinational read ports and one write port.
// Entry 0 is hardwired to zero. BYPASS selects write-first forwarding on the read ports.

module regfile_entry #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module regfile_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                                rst_n,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  mem,
    input  logic                                wen,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [ADDR_W-1:0]                   raddr,
    output logic [DATA_W-1:0]                   rdata
);
    logic hit;

    assign hit = (BYPASS != 0) && wen && (waddr != '0) && (waddr == raddr);

    // Reset and r0 take priority over forwarding so a write held during reset never leaks out.
    always_comb begin
        rdata = mem[raddr];
        if (hit)                        rdata = wdata;
        if (!rst_n || raddr == '0)      rdata = '0;
    end
endmodule

module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    assign mem[0] = '0;

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_entry
            logic sel;
            assign sel = wen && (waddr == ADDR_W'(i));
            regfile_entry #(.DATA_W(DATA_W)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (sel),
                .d     (wdata),
                .q     (mem[i])
            );
        end
    endgenerate

    regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rport1 (
        .rst_n (rst_n),
        .mem   (mem),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr1),
        .rdata (rdata1)
    );

    regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rport2 (
        .rst_n (rst_n),
        .mem   (mem),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr2),
        .rdata (rdata2)
    );
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one forwarding instance and one non-forwarding
// instance share the same stimulus.

module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        #1;
        chk("rst_r1", rdata1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // 1. async reset clears loaded entry before the next edge
        wr(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5; #1;
        chk("r5_loaded", rdata1, 32'hDEADBEEF);
        #1 rst_n = 1'b0; #1;
        chk("r5_async_rst", rdata1, 32'h0);
        chk("r5_async_rst_nb", nb_rdata1, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i); #1;
            chk($sformatf("post_rst_p1_%0d", i), rdata1, 32'h0);
            chk($sformatf("post_rst_p2_%0d", i), rdata2, 32'h0);
        end

        // 2. basic write/read
        wr(5'd7, 32'h12345678);
        raddr1 = 5'd7; raddr2 = 5'd7; #1;
        chk("r7_p1", rdata1, 32'h12345678);
        chk("r7_p2", rdata2, 32'h12345678);
        raddr1 = 5'd8; #1;
        chk("r8_p1", rdata1, 32'h0);

        // 3. r0 stays zero, even with forwarding in play
        @(negedge clk);
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; #1;
        chk("r0_during", rdata1, 32'h0);
        @(posedge clk); #1; wen = 1'b0; #1;
        chk("r0_after", rdata1, 32'h0);

        // 4. forwarding vs stored value
        wr(5'd3, 32'h00000011);
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h00000022; raddr1 = 5'd3; raddr2 = 5'd4; #1;
        chk("byp_r1", rdata1, 32'h00000022);
        chk("byp_r2_r4", rdata2, 32'h0);
        chk("nobyp_r1_pre", nb_rdata1, 32'h00000011);
        @(posedge clk); #1; wen = 1'b0; #1;
        chk("byp_r1_post", rdata1, 32'h00000022);
        chk("nobyp_r1_post", nb_rdata1, 32'h00000022);
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h00000033; raddr1 = 5'd3; raddr2 = 5'd3; #1;
        chk("byp_both_p1", rdata1, 32'h00000033);
        chk("byp_both_p2", rdata2, 32'h00000033);
        chk("nobyp_both_p2", nb_rdata2, 32'h00000022);
        @(posedge clk); #1; wen = 1'b0;

        // 5. wen gating, then full fill and crossed readback
        @(negedge clk);
        wen = 1'b0; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        #1 raddr1 = 5'd9; #1;
        chk("r9_gated", rdata1, 32'h0);
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
            chk($sformatf("fill_p1_%0d", i), rdata1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            chk($sformatf("fill_p2_%0d", 31 - i), rdata2, (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
            chk($sformatf("fill_nb_%0d", i), nb_rdata1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
        end

        // 6. reset held across a write edge
        @(negedge clk);
        wen = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D; raddr1 = 5'd12; raddr2 = 5'd5;
        #2 rst_n = 1'b0; #1;
        chk("rst_wr_byp_gated", rdata1, 32'h0);
        @(posedge clk); #1;
        chk("rst_wr_r12_in_rst", rdata1, 32'h0);
        @(negedge clk);
        wen = 1'b0; rst_n = 1'b1; #1;
        chk("rst_wr_r12", rdata1, 32'h0);
        chk("rst_wr_r5", rdata2, 32'h0);
        wr(5'd12, 32'h0BADF00D);
        #1;
        chk("r12_after_rst", rdata1, 32'h0BADF00D);
        chk("r12_after_rst_nb", nb_rdata1, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
